// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter:
//   arb_state_e : FSM encoding (ST_IDLE=0, ST_GRANT=1)
//   idx_w()     : index width for an N-entry one-hot vector (never below 1)
package rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick.
//   req : request vector
//   ptr : highest-priority position for this pick
//   any : at least one request set
//   idx : first set request scanning ptr, ptr+1, ..., wrapping to ptr-1
// Rotates req so ptr lands at bit 0, takes the lowest set bit, then adds
// ptr back (mod N) to recover the absolute index.
module rr_arbiter_pick
  import rr_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] NN = (IW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  k;
  logic [IW:0]    sum;

  // Doubling the vector makes the right shift a rotate.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  assign any = |req;

  always_comb begin
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) k = IW'(i);
    end
  end

  // Un-rotate; sum < 2N so one conditional subtract gives mod N.
  assign sum = {1'b0, k} + {1'b0, ptr};
  assign idx = (sum >= NN) ? IW'(sum - NN) : sum[IW-1:0];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one shared combinational resource.
//   clk, rst  : clock, asynchronous active-high reset
//   req[N]    : level requests, held until served
//   done      : current owner releases the resource
//   gnt[N]    : registered one-hot grant, zero when idle
//   gnt_valid : |gnt (registered alongside gnt)
//   gnt_id    : binary owner index, zero when idle
//   timeout   : one-cycle pulse after a release forced only by MAX_HOLD
// A grant is held until done, the owner drops its request, or the owner has
// held it MAX_HOLD cycles (MAX_HOLD=0 disables the limit). Every release goes
// through IDLE, so consecutive grants are separated by one dead cycle.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW = idx_w(N),
  localparam int HW = $clog2(MAX_HOLD) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id,
  output logic          timeout
);

  localparam logic [N-1:0]  ONE   = N'(1);
  localparam logic [HW-1:0] LIMIT = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST  = IW'(N - 1);

  arb_state_e    state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [N-1:0]  gnt_n;
  logic [IW-1:0] id_n;
  logic          to_n;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          at_limit, owner_req, release_now;

  rr_arbiter_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign at_limit    = (MAX_HOLD != 0) && (hold_cnt == LIMIT);
  assign owner_req   = req[gnt_id];
  assign release_now = done || !owner_req || at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      gnt_valid <= |gnt_n;
      gnt_id    <= id_n;
      timeout   <= to_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    gnt_n   = gnt;
    id_n    = gnt_id;
    to_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_n = ST_GRANT;
          gnt_n   = ONE << pick_idx;
          id_n    = pick_idx;
          hold_n  = '0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_n = ST_IDLE;
          gnt_n   = '0;
          id_n    = '0;
          ptr_n   = (gnt_id == LAST) ? '0 : gnt_id + 1'b1;
          // Flag only when the limit alone ended the grant.
          to_n    = at_limit && !done && owner_req;
        end else if (hold_cnt != '1) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
